// File: rtl/bcd_a_contadores.sv
// bcd_a_contadores: two-digit BCD field loader for the time counters.
// Reverse double-dabble over 8 cycles, range check, then one register write.
module bcd_a_contadores (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_sel,
   input  logic [3:0] in_tens,
   input  logic [3:0] in_ones,
   output logic [7:0] countsecs,
   output logic [7:0] countmins,
   output logic [7:0] counthours,
   output logic [7:0] countdays,
   output logic [7:0] countmonths,
   output logic [7:0] countyears,
   output logic [5:0] upd,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [2:0] SEL_SECS   = 3'd0;
   localparam logic [2:0] SEL_MINS   = 3'd1;
   localparam logic [2:0] SEL_HOURS  = 3'd2;
   localparam logic [2:0] SEL_DAYS   = 3'd3;
   localparam logic [2:0] SEL_MONTHS = 3'd4;
   localparam logic [2:0] SEL_YEARS  = 3'd5;

   state_t      state;
   state_t      state_nx;

   logic [15:0] scr;
   logic [15:0] scr_sh;
   logic [15:0] scr_nx;
   logic [2:0]  it;
   logic [2:0]  sel;
   logic        bad;

   logic        accept;
   logic        in_bad;
   logic        last_it;
   logic [7:0]  val;
   logic [7:0]  lo;
   logic [7:0]  hi;
   logic        range_bad;
   logic        bad_fin;
   logic [5:0]  upd_hot;

   assign accept  = in_valid & in_ready;
   assign last_it = (it == 3'd7);
   assign val     = scr[7:0];

   assign in_bad = (in_tens > 4'd9) |
                   (in_ones > 4'd9) |
                   (in_sel  > 3'd5);

   // One reverse double-dabble step: shift right, then pull
   // each BCD nibble back into range by subtracting 3.
   always_comb begin
      scr_sh = {1'b0, scr[15:1]};
      scr_nx = scr_sh;
      if (scr_sh[15:12] >= 4'd8)
         scr_nx[15:12] = scr_sh[15:12] - 4'd3;
      if (scr_sh[11:8] >= 4'd8)
         scr_nx[11:8] = scr_sh[11:8] - 4'd3;
   end

   always_comb begin
      lo = 8'd0;
      hi = 8'd0;
      case (sel)
         SEL_SECS: begin
            lo = 8'd0;
            hi = 8'd59;
         end
         SEL_MINS: begin
            lo = 8'd0;
            hi = 8'd59;
         end
         SEL_HOURS: begin
            lo = 8'd0;
            hi = 8'd23;
         end
         SEL_DAYS: begin
            lo = 8'd1;
            hi = 8'd31;
         end
         SEL_MONTHS: begin
            lo = 8'd1;
            hi = 8'd12;
         end
         SEL_YEARS: begin
            lo = 8'd0;
            hi = 8'd99;
         end
         default: begin
            lo = 8'd0;
            hi = 8'd0;
         end
      endcase
   end

   assign range_bad = (val < lo) | (val > hi);
   assign bad_fin   = bad | range_bad;

   always_comb begin
      upd_hot = 6'd0;
      case (sel)
         SEL_SECS:   upd_hot = 6'b000001;
         SEL_MINS:   upd_hot = 6'b000010;
         SEL_HOURS:  upd_hot = 6'b000100;
         SEL_DAYS:   upd_hot = 6'b001000;
         SEL_MONTHS: upd_hot = 6'b010000;
         SEL_YEARS:  upd_hot = 6'b100000;
         default:    upd_hot = 6'b000000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept)
               state_nx = SHIFT;
         end
         SHIFT: begin
            if (last_it)
               state_nx = CHECK;
         end
         CHECK: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Scratch, counter and captured request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scr <= 16'd0;
         it  <= 3'd0;
         sel <= 3'd0;
         bad <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  scr <= {in_tens, in_ones, 8'h00};
                  it  <= 3'd0;
                  sel <= in_sel;
                  bad <= in_bad;
               end
            end
            SHIFT: begin
               scr <= scr_nx;
               it  <= it + 3'd1;
            end
            default: begin
               scr <= scr;
            end
         endcase
      end
   end

   // Field registers and the one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         countsecs   <= 8'd0;
         countmins   <= 8'd0;
         counthours  <= 8'd0;
         countdays   <= 8'd1;
         countmonths <= 8'd1;
         countyears  <= 8'd0;
         upd         <= 6'd0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         upd  <= 6'd0;
         done <= 1'b0;
         err  <= 1'b0;
         if (state == CHECK) begin
            done <= 1'b1;
            err  <= bad_fin;
            if (!bad_fin) begin
               upd <= upd_hot;
               case (sel)
                  SEL_SECS:   countsecs   <= val;
                  SEL_MINS:   countmins   <= val;
                  SEL_HOURS:  counthours  <= val;
                  SEL_DAYS:   countdays   <= val;
                  SEL_MONTHS: countmonths <= val;
                  SEL_YEARS:  countyears  <= val;
                  default:    countsecs   <= countsecs;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_a_contadores.sv
// tb_bcd_a_contadores: directed and random loads against an
// arithmetic model of the BCD field loader.
module tb_bcd_a_contadores;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_sel;
   logic [3:0] in_tens;
   logic [3:0] in_ones;
   logic [7:0] countsecs;
   logic [7:0] countmins;
   logic [7:0] counthours;
   logic [7:0] countdays;
   logic [7:0] countmonths;
   logic [7:0] countyears;
   logic [5:0] upd;
   logic       done;
   logic       err;

   int passed;
   int total;
   int mdl[6];
   int lo_t[6] = '{0, 0, 0, 1, 1, 0};
   int hi_t[6] = '{59, 59, 23, 31, 12, 99};
   int rst_t[6] = '{0, 0, 0, 1, 1, 0};

   bcd_a_contadores dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sel      (in_sel),
      .in_tens     (in_tens),
      .in_ones     (in_ones),
      .countsecs   (countsecs),
      .countmins   (countmins),
      .counthours  (counthours),
      .countdays   (countdays),
      .countmonths (countmonths),
      .countyears  (countyears),
      .upd         (upd),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time expired, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs === exp)
         passed++;
      else
         $display("FAIL %s: got %0d required %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++)
         mdl[i] = rst_t[i];
   endtask

   task automatic chk_regs(input string tag);
      logic [7:0] obs[6];
      obs[0] = countsecs;
      obs[1] = countmins;
      obs[2] = counthours;
      obs[3] = countdays;
      obs[4] = countmonths;
      obs[5] = countyears;
      for (int i = 0; i < 6; i++)
         chk($sformatf("%s.reg%0d", tag, i), 32'(obs[i]), 32'(mdl[i]));
   endtask

   // Accept at E0, watch E1..E8, check the result after E9.
   task automatic load(input int s, input int t, input int o);
      int  lowc;
      int  pulses;
      int  v;
      bit  bad;
      in_sel   = 3'(s);
      in_tens  = 4'(t);
      in_ones  = 4'(o);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      lowc   = 0;
      pulses = 0;
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'($urandom);
         in_sel   = 3'($urandom);
         in_tens  = 4'($urandom);
         in_ones  = 4'($urandom);
         if (!in_ready)
            lowc++;
         if (done || err || upd != 6'd0)
            pulses++;
         if (k < 8) begin
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      v   = t * 10 + o;
      bad = (t > 9) || (o > 9) || (s > 5);
      if (!bad)
         bad = (v < lo_t[s]) || (v > hi_t[s]);
      if (!bad)
         mdl[s] = v;
      chk("busy_cycles", 32'(lowc), 32'd9);
      chk("early_pulse", 32'(pulses), 32'd0);
      chk("done", 32'(done), 32'd1);
      chk("err", 32'(err), 32'(bad));
      chk("upd", 32'(upd), bad ? 32'd0 : (32'd1 << s));
      chk("ready_at_done", 32'(in_ready), 32'd1);
      chk_regs($sformatf("load%0d_%0d%0d", s, t, o));
   endtask

   initial begin
      int dcnt;
      int dpos[$];
      int rs;
      int rt;
      int ro;
      passed   = 0;
      total    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sel   = 3'd0;
      in_tens  = 4'd0;
      in_ones  = 4'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_upd", 32'(upd), 32'd0);
      chk_regs("rst");

      load(0, 5, 9);
      load(2, 2, 4);
      load(2, 2, 3);
      load(3, 0, 0);
      load(4, 1, 2);
      load(5, 9, 9);
      load(1, 10, 3);
      load(6, 1, 0);
      load(3, 3, 1);
      load(3, 3, 2);
      load(4, 0, 0);
      load(4, 1, 3);

      // Reset after E4 of a secs=45 load.
      in_sel   = 3'd0;
      in_tens  = 4'd4;
      in_ones  = 4'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      chk("abort_upd", 32'(upd), 32'd0);
      chk_regs("abort");
      dcnt = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || upd != 6'd0)
            dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      load(1, 3, 0);

      // in_valid held high: one accept per IDLE visit.
      in_sel   = 3'd0;
      in_tens  = 4'd0;
      in_ones  = 4'd7;
      in_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (c == 29)
            in_valid = 1'b0;
         if (done)
            dpos.push_back(c);
      end
      mdl[0] = 7;
      chk("hold_count", 32'(dpos.size()), 32'd3);
      if (dpos.size() == 3) begin
         chk("hold_gap1", 32'(dpos[1] - dpos[0]), 32'd10);
         chk("hold_gap2", 32'(dpos[2] - dpos[1]), 32'd10);
      end
      chk_regs("hold");

      for (int n = 0; n < 60; n++) begin
         rs = ($urandom_range(0, 9) == 0) ? 6 + int'($urandom_range(0, 1))
                                         : int'($urandom_range(0, 5));
         rt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(0, 9));
         ro = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(0, 9));
         load(rs, rt, ro);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
